// File: rtl/spi_sram_pkg.sv
// Shared constants and types for the SPI SRAM responder.
package spi_sram_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned PAGE_W = 5;

  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h03;
  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h02;
  localparam logic [BYTE_W-1:0] CMD_RDMR  = 8'h05;
  localparam logic [BYTE_W-1:0] CMD_WRMR  = 8'h01;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    ADDR    = 3'd2,
    RDATA   = 3'd3,
    WDATA   = 3'd4,
    MODE_RD = 3'd5,
    MODE_WR = 3'd6,
    IGNORE  = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    MODE_BYTE = 2'b00,
    MODE_SEQ  = 2'b01,
    MODE_PAGE = 2'b10,
    MODE_RSVD = 2'b11
  } mode_t;

endpackage

// File: rtl/spi_sram_resp_mem.sv
// Byte array behind the SPI SRAM responder: synchronous write, asynchronous read.
module spi_sram_resp_mem
  import spi_sram_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [BYTE_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [BYTE_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [BYTE_W-1:0] mem_q [DEPTH];

  // Byte write on the clock edge; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational read so a byte can be loaded and driven in the same edge.
  assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/spi_sram_responder.sv
// SPI SRAM target: decodes READ/WRITE frames with a 24-bit address on cs_n/mosi/miso,
// clocked directly by clk (no separate sclk).
// Optional mode register (RDMR/WRMR, BYTE/PAGE/SEQ) enabled by SPI_SRAM_RESP_MODE_REG_EN.
module spi_sram_responder
  import spi_sram_pkg::*;
#(
  parameter int unsigned AW = 17
) (
  input  logic clk,
  input  logic arst_n,
  input  logic cs_n,
  input  logic mosi,
  output logic miso,
  output logic busy
);

  state_t            state_q, state_d;
  logic [2:0]        bitcnt_q, bitcnt_d;
  logic [1:0]        acnt_q, acnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              is_rd_q, is_rd_d;
  logic              miso_q, miso_d;
  logic              busy_q;
  mode_t             mode_c;

  logic [BYTE_W-1:0] byte_in_c;
  logic [AW-1:0]     addr_in_c;
  logic              we_c;
  logic [AW-1:0]     raddr_c;
  logic [BYTE_W-1:0] rdata_c;

`ifdef SPI_SRAM_RESP_MODE_REG_EN
  mode_t mode_q, mode_d;
  assign mode_c = mode_q;
`else
  assign mode_c = MODE_SEQ;
`endif

  // Next address: PAGE mode keeps the upper bits and wraps within the 32-byte page.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a, input mode_t m);
    logic [AW-1:0] n;
    n = a + AW'(1);
    if (m == MODE_PAGE) begin
      n = {a[AW-1:PAGE_W], PAGE_W'(a[PAGE_W-1:0] + PAGE_W'(1))};
    end
    return n;
  endfunction

  assign byte_in_c = {shift_q[BYTE_W-2:0], mosi};
  assign addr_in_c = {addr_q[AW-2:0], mosi};
  // The first data byte is read at the freshly assembled address on the last address bit.
  assign raddr_c   = (state_q == ADDR) ? addr_in_c : addr_q;

  spi_sram_resp_mem #(.AW(AW)) u_mem (
    .clk     (clk),
    .we_i    (we_c),
    .waddr_i (addr_q),
    .wdata_i (byte_in_c),
    .raddr_i (raddr_c),
    .rdata_c (rdata_c)
  );

  // Frame decoder: command, address, data phases and miso launch.
  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    acnt_d   = acnt_q;
    shift_d  = shift_q;
    addr_d   = addr_q;
    is_rd_d  = is_rd_q;
    miso_d   = 1'b0;
    we_c     = 1'b0;
`ifdef SPI_SRAM_RESP_MODE_REG_EN
    mode_d   = mode_q;
`endif
    if (cs_n) begin
      state_d  = IDLE;
      bitcnt_d = 3'd0;
      acnt_d   = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          shift_d  = byte_in_c;
          bitcnt_d = 3'd1;
          state_d  = CMD;
        end
        CMD: begin
          shift_d  = byte_in_c;
          bitcnt_d = 3'(bitcnt_q + 3'd1);
          if (bitcnt_q == 3'd7) begin
            acnt_d = 2'd0;
            case (byte_in_c)
              CMD_READ: begin
                is_rd_d = 1'b1;
                state_d = ADDR;
              end
              CMD_WRITE: begin
                is_rd_d = 1'b0;
                state_d = ADDR;
              end
`ifdef SPI_SRAM_RESP_MODE_REG_EN
              CMD_RDMR: begin
                miso_d   = mode_c[1];
                shift_d  = {mode_c[0], 7'd0};
                bitcnt_d = 3'd1;
                state_d  = MODE_RD;
              end
              CMD_WRMR: state_d = MODE_WR;
`endif
              default: state_d = IGNORE;
            endcase
          end
        end
        ADDR: begin
          addr_d   = addr_in_c;
          bitcnt_d = 3'(bitcnt_q + 3'd1);
          if (bitcnt_q == 3'd7) begin
            acnt_d = 2'(acnt_q + 2'd1);
            if (acnt_q == 2'd2) begin
              if (is_rd_q) begin
                miso_d   = rdata_c[BYTE_W-1];
                shift_d  = {rdata_c[BYTE_W-2:0], 1'b0};
                addr_d   = addr_inc(addr_in_c, mode_c);
                bitcnt_d = 3'd1;
                state_d  = RDATA;
              end else begin
                state_d  = WDATA;
              end
            end
          end
        end
        RDATA: begin
          if (bitcnt_q == 3'd0) begin
            if (mode_c == MODE_BYTE) begin
              state_d = IGNORE;
            end else begin
              miso_d   = rdata_c[BYTE_W-1];
              shift_d  = {rdata_c[BYTE_W-2:0], 1'b0};
              addr_d   = addr_inc(addr_q, mode_c);
              bitcnt_d = 3'd1;
            end
          end else begin
            miso_d   = shift_q[BYTE_W-1];
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            bitcnt_d = 3'(bitcnt_q + 3'd1);
          end
        end
        WDATA: begin
          shift_d  = byte_in_c;
          bitcnt_d = 3'(bitcnt_q + 3'd1);
          if (bitcnt_q == 3'd7) begin
            we_c   = 1'b1;
            addr_d = addr_inc(addr_q, mode_c);
            if (mode_c == MODE_BYTE) begin
              state_d = IGNORE;
            end
          end
        end
`ifdef SPI_SRAM_RESP_MODE_REG_EN
        MODE_RD: begin
          if (bitcnt_q == 3'd0) begin
            state_d = IGNORE;
          end else begin
            miso_d   = shift_q[BYTE_W-1];
            shift_d  = {shift_q[BYTE_W-2:0], 1'b0};
            bitcnt_d = 3'(bitcnt_q + 3'd1);
          end
        end
        MODE_WR: begin
          shift_d  = byte_in_c;
          bitcnt_d = 3'(bitcnt_q + 3'd1);
          if (bitcnt_q == 3'd7) begin
            mode_d  = mode_t'(byte_in_c[7:6]);
            state_d = IGNORE;
          end
        end
`endif
        IGNORE: state_d = IGNORE;
        default: state_d = IGNORE;
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= 3'd0;
      acnt_q   <= 2'd0;
      shift_q  <= '0;
      addr_q   <= '0;
      is_rd_q  <= 1'b0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      acnt_q   <= acnt_d;
      shift_q  <= shift_d;
      addr_q   <= addr_d;
      is_rd_q  <= is_rd_d;
      miso_q   <= miso_d;
      busy_q   <= (state_d != IDLE);
    end
  end

`ifdef SPI_SRAM_RESP_MODE_REG_EN
  // Mode register, SEQ out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      mode_q <= MODE_SEQ;
    end else begin
      mode_q <= mode_d;
    end
  end
`endif

  assign miso = miso_q;
  assign busy = busy_q;

endmodule
